f32_add_arbiter: RTL and testbench
==================================

// Module: f32_add_arbiter
// PURPOSE
//  Shares one pipelined f32 adder (__adler32__add_two_f32, ports clk/a/b/out) among NUM_REQ requesters.
//  Round-robin arbitration, one issue per cycle, valid/ready request handshake.
//  Tags each issued op and routes the adder result back to its requester after the fixed pipeline latency.
//  Adder is instantiated outside this block; this block drives its a/b and samples its out.
// PARAMETERS
//  NUM_REQ      4  number of requesters (>=2)
//  ADD_LATENCY  3  cycles from operands present on add_a/add_b to result valid on add_out (>=1)
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NUM_REQ     per-requester request valid
//  req_a      in   NUM_REQ*32  operand a, requester i at [32*i +: 32]
//  req_b      in   NUM_REQ*32  operand b, same packing
//  req_ready  out  NUM_REQ     one-hot grant; transfer = req_valid[i] & req_ready[i]
//  resp_valid out  NUM_REQ     one-cycle pulse, result for requester i on resp_data
//  resp_data  out  32          f32 sum, meaningful only while any resp_valid bit is set
//  add_a      out  32          to adder a (registered)
//  add_b      out  32          to adder b (registered)
//  add_out    in   32          from adder out
//  in_flight  out  $clog2(ADD_LATENCY+3)  accepted ops not yet responded
// BEHAVIOUR
//  Reset (rst=1 at posedge): rr_ptr=0, add_a=add_b=0, resp_valid=0, resp_data=0, in_flight=0,
//   all tag-pipeline valid bits cleared. Ops in flight are dropped; adder outputs emerging later are ignored.
//  Arbitration (combinational): grant the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   req_ready = one-hot of that i, 0 if no req_valid. req_ready=0 while rst=1.
//   On transfer: rr_ptr <= (i+1) mod NUM_REQ; no transfer -> rr_ptr holds.
//   Requester holds req_valid and operands stable until its transfer; dropping req_valid early is legal (no grant then).
//  Issue: on transfer at edge E0, add_a/add_b <= granted operands; stage0 {valid,tag=i} <= {1,i}.
//   No transfer: stage0 valid <= 0, add_a/add_b hold previous values.
//  Tag pipeline: ADD_LATENCY+1 stages of {valid,tag} shifting every cycle, no stalls.
//   Final stage aligns with add_out for the operands issued at E0.
//  Response: registered. resp_valid[tag] <= final-stage valid, resp_data <= add_out.
//   Latency: handshake in cycle t -> resp_valid pulse in cycle t+ADD_LATENCY+2 (default 5).
//  No response backpressure: requester must consume resp in its pulse cycle.
//  Throughput 1 op/cycle; results return in issue order; at most one resp_valid bit set per cycle.
//  in_flight: +1 on transfer, -1 on resp pulse, unchanged when both same cycle; max ADD_LATENCY+2.
//  Arithmetic: none in this block; sum/rounding entirely from the adder. Operands passed bit-exact.
// TESTING  (bench instantiates __adler32__add_two_f32 with matching ADD_LATENCY)
//  1 Single req0: a=0x4019999a (2.4), b=0x40966666 (4.7) -> req_ready[0] same cycle; resp_valid=4'b0001,
//    resp_data=0x40e33333 (7.1) exactly 5 cycles later; in_flight 1 then 0.
//  2 All 4 valid from reset, each 0x3f800000+0x3f800000 -> grants 0,1,2,3 on consecutive cycles;
//    resp pulses bits 0..3 in order, each resp_data=0x40000000.
//  3 req1 and req3 held continuously, rr_ptr=2 -> grants 3,1,3,1...; ptr wraps 3->0; no starvation.
//  4 Req2 back-to-back 5 ops (distinct operands) -> 5 consecutive resp_valid[2] pulses, correct sums, in_flight peaks 5.
//  5 Assert rst 2 cycles after issuing 2 ops -> no resp_valid ever for those ops; outputs/in_flight 0; grant restarts at req0.
//  6 Transfer and resp in same cycle -> in_flight unchanged; no req_valid -> req_ready=0, add_a/add_b hold.

Source files
------------

// File: rtl/f32_add_arbiter.sv
// ---------------------------------------------------------------------------
// f32_add_arbiter
//
// Shares one externally instantiated, fully pipelined f32 adder among
// NUM_REQ requesters. Each cycle at most one request is granted using a
// round-robin scan that starts at rr_ptr. The granted operands are
// registered onto add_a/add_b, and a {valid, tag} token travels down a
// shift pipeline that lines up with the adder latency. When the token
// reaches the end, the adder result is registered onto resp_data and the
// matching resp_valid bit pulses for one cycle.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : synchronous, active-high reset
//   req_valid  : per-requester request valid            [NUM_REQ]
//   req_a      : operand a, requester i at [32*i +: 32] [NUM_REQ*32]
//   req_b      : operand b, same packing                [NUM_REQ*32]
//   req_ready  : one-hot grant                          [NUM_REQ]
//   resp_valid : one-cycle result pulse per requester   [NUM_REQ]
//   resp_data  : f32 sum, meaningful while resp_valid != 0
//   add_a      : registered operand a to the adder
//   add_b      : registered operand b to the adder
//   add_out    : adder result, ADD_LATENCY cycles after add_a/add_b
//   in_flight  : accepted ops whose response pulse has not finished
//
// Handshake: a request transfers in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready never depends on anything except
// req_valid, rr_ptr and rst, so a requester may drop req_valid at any time
// before its transfer; once it transfers it sees its result exactly
// ADD_LATENCY+2 cycles later. Responses cannot be back-pressured.
// ---------------------------------------------------------------------------
module f32_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*32-1:0]              req_a,
    input  logic [NUM_REQ*32-1:0]              req_b,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [31:0]                        resp_data,
    output logic [31:0]                        add_a,
    output logic [31:0]                        add_b,
    input  logic [31:0]                        add_out,
    output logic [$clog2(ADD_LATENCY+3)-1:0]   in_flight
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ADD_LATENCY + 3);

    // Unpacked views of the operand buses, indexed by requester.
    logic [31:0] op_a [NUM_REQ];
    logic [31:0] op_b [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[32*g +: 32];
        assign op_b[g] = req_b[32*g +: 32];
    end

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic [IDX_W-1:0] ptr_next;
    logic             transfer;
    int               scan_idx;
    logic [IDX_W-1:0] scan_sel;

    // Tag pipeline: stage 0 is written on the same edge as add_a/add_b, so
    // stage ADD_LATENCY is valid exactly when add_out holds that op's sum.
    logic [ADD_LATENCY:0] stage_valid;
    logic [IDX_W-1:0]     stage_tag [ADD_LATENCY+1];

    logic [NUM_REQ-1:0]   resp_next;
    logic                 resp_any;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        scan_sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            scan_sel = IDX_W'(scan_idx);
            if (!grant_found && req_valid[scan_sel]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sel;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);
    assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        resp_next = '0;
        if (stage_valid[ADD_LATENCY]) begin
            resp_next[stage_tag[ADD_LATENCY]] = 1'b1;
        end
    end

    // An op stops counting on the edge that ends its response pulse.
    assign resp_any = |resp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            add_a       <= '0;
            add_b       <= '0;
            stage_valid <= '0;
            for (int k = 0; k <= ADD_LATENCY; k++) begin
                stage_tag[k] <= '0;
            end
            resp_valid  <= '0;
            resp_data   <= '0;
            in_flight   <= '0;
        end else begin
            if (transfer) begin
                rr_ptr <= ptr_next;
                add_a  <= op_a[grant_idx];
                add_b  <= op_b[grant_idx];
            end

            stage_valid[0] <= transfer;
            stage_tag[0]   <= grant_idx;
            for (int k = 1; k <= ADD_LATENCY; k++) begin
                stage_valid[k] <= stage_valid[k-1];
                stage_tag[k]   <= stage_tag[k-1];
            end

            resp_valid <= resp_next;
            resp_data  <= add_out;

            case ({transfer, resp_any})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_f32_add_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for f32_add_arbiter. A behavioural pipelined f32 adder stands in for
// the shared adder. A monitor keeps a reference model built from the
// arbitration rules (round-robin pointer, fixed response latency, in-order
// results) and checks every cycle; scenario tasks add targeted checks.
// ---------------------------------------------------------------------------
module tb_f32_add_arbiter;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(L + 3);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [31:0]     add_out;
  logic [CW-1:0]   in_flight;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  f32_add_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_out    (add_out),
    .in_flight  (in_flight)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got time %0t want < 200000", $time);
    $fatal(1, "timeout");
  end

  // ---------------- f32 reference arithmetic ----------------
  // Operands are normal numbers with exponents close together, so the sum is
  // exact in double precision and a single round-to-nearest-even to f32
  // reproduces the IEEE f32 sum.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [31:0] base;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = int'(d[62:52]) - 896;
    base = {d[63], e[7:0], d[51:29]};
    if (d[28] && ((d[27:0] != 28'd0) || d[29])) base = base + 32'd1;
    return base;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_f32();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(120, 135));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  // Behavioural shared adder: L-cycle pipeline.
  logic [31:0] add_pipe [L];
  always @(posedge clk) begin
    add_pipe[0] <= fadd(add_a, add_b);
    for (int k = 1; k < L; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_out = add_pipe[L-1];

  // ---------------- scoreboard / monitor ----------------
  logic [IW+31:0] exp_q[$];   // {tag, sum} in issue order
  int             due_q[$];   // cycle in which each response must pulse
  int             hs_q[$];    // handshake cycles, for in_flight
  int             m_ptr = 0;
  logic [31:0]    m_add_a = '0;
  logic [31:0]    m_add_b = '0;

  always @(negedge clk) begin : monitor
    int             n;
    int             idx;
    logic [N-1:0]   er;
    logic [N-1:0]   ev;
    logic [IW+31:0] e;
    if (rst) begin
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL mon_ready_in_reset: got %b want 0", req_ready);
      end
      exp_q.delete();
      due_q.delete();
      hs_q.delete();
      m_ptr   = 0;
      m_add_a = '0;
      m_add_b = '0;
    end else begin
      n = 0;
      foreach (hs_q[i]) if (cyc > hs_q[i] && cyc <= hs_q[i] + L + 2) n++;
      while (hs_q.size() > 0 && hs_q[0] + L + 2 < cyc) void'(hs_q.pop_front());
      checks++;
      if (in_flight !== CW'(n)) begin
        errors++;
        $display("FAIL mon_in_flight cyc %0d: got %0d want %0d", cyc, in_flight, n);
      end

      ev = '0;
      e  = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        ev[e[IW+31:32]] = 1'b1;
      end
      checks++;
      if (resp_valid !== ev) begin
        errors++;
        $display("FAIL mon_resp_valid cyc %0d: got %b want %b", cyc, resp_valid, ev);
      end
      if (ev != '0) begin
        checks++;
        if (resp_data !== e[31:0]) begin
          errors++;
          $display("FAIL mon_resp_data cyc %0d: got %h want %h", cyc, resp_data, e[31:0]);
        end
      end

      checks++;
      if (add_a !== m_add_a || add_b !== m_add_b) begin
        errors++;
        $display("FAIL mon_add_operands cyc %0d: got %h/%h want %h/%h",
                 cyc, add_a, add_b, m_add_a, m_add_b);
      end

      er = '0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (er == '0 && req_valid[idx]) er[idx] = 1'b1;
      end
      checks++;
      if (req_ready !== er) begin
        errors++;
        $display("FAIL mon_req_ready cyc %0d: got %b want %b", cyc, req_ready, er);
      end

      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && er[i]) begin
          exp_q.push_back({IW'(i), fadd(req_a[32*i +: 32], req_b[32*i +: 32])});
          due_q.push_back(cyc + L + 2);
          hs_q.push_back(cyc);
          m_ptr   = (i + 1) % N;
          m_add_a = req_a[32*i +: 32];
          m_add_b = req_b[32*i +: 32];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (L + 4) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    tick();
    tick();
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== '0 || resp_data !== 32'd0 || add_a !== 32'd0 ||
        add_b !== 32'd0 || in_flight !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b rd=%h a=%h b=%h if=%0d want all 0",
               resp_valid, resp_data, add_a, add_b, in_flight);
    end
  endtask

  task automatic test_single();
    tick();
    req_valid = 4'b0001;
    set_req(0, 32'h4019999a, 32'h40966666);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (in_flight !== CW'(1)) begin
      errors++;
      $display("FAIL single_in_flight_1: got %0d want 1", in_flight);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || resp_data !== 32'h40e33333) begin
      errors++;
      $display("FAIL single_resp: got %b/%h want 0001/40e33333", resp_valid, resp_data);
    end
    @(negedge clk);
    checks++;
    if (in_flight !== '0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL single_in_flight_0: got %0d/%b want 0/0000", in_flight, resp_valid);
    end
  endtask

  task automatic test_all_four();
    int got;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 32'h3f800000, 32'h3f800000);
    req_valid = '1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== (4'b0001 << k)) begin
        errors++;
        $display("FAIL all4_grant_%0d: got %b want %b", k, req_ready, 4'b0001 << k);
      end
      tick();
      req_valid[k] = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        checks++;
        if (resp_valid !== (4'b0001 << got) || resp_data !== 32'h40000000) begin
          errors++;
          $display("FAIL all4_resp_%0d: got %b/%h want %b/40000000",
                   got, resp_valid, resp_data, 4'b0001 << got);
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL all4_resp_count: got %0d want 4", got);
    end
  endtask

  task automatic test_rr_pair();
    logic [N-1:0] want;
    tick();
    req_valid = 4'b0010;
    set_req(1, rnd_f32(), rnd_f32());
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rr_setup_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b1010;
    set_req(1, rnd_f32(), rnd_f32());
    set_req(3, rnd_f32(), rnd_f32());
    for (int k = 0; k < 8; k++) begin
      want = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      @(negedge clk);
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL rr_pair_grant_%0d: got %b want %b", k, req_ready, want);
      end
      tick();
      set_req((k % 2 == 0) ? 3 : 1, rnd_f32(), rnd_f32());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] sums [5];
    logic [31:0] a;
    logic [31:0] b;
    int          got;
    int          first_c;
    int          last_c;
    int          peak;
    tick();
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      a = rnd_f32();
      b = rnd_f32();
      set_req(2, a, b);
      sums[k] = fadd(a, b);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL b2b_grant_%0d: got %b want 0100", k, req_ready);
      end
      tick();
    end
    req_valid = '0;
    got = 0;
    first_c = -1;
    last_c = -1;
    peak = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (resp_valid == 4'b0100 && got < 5) begin
        checks++;
        if (resp_data !== sums[got]) begin
          errors++;
          $display("FAIL b2b_data_%0d: got %h want %h", got, resp_data, sums[got]);
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        got++;
      end
    end
    checks++;
    if (got != 5 || last_c - first_c != 4) begin
      errors++;
      $display("FAIL b2b_pulses: got count %0d span %0d want 5/4", got, last_c - first_c);
    end
    checks++;
    if (peak != 5) begin
      errors++;
      $display("FAIL b2b_peak_in_flight: got %0d want 5", peak);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    req_valid = 4'b0010;
    set_req(1, rnd_f32(), rnd_f32());
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_grant_1: got %b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b0100;
    set_req(2, rnd_f32(), rnd_f32());
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rmid_grant_2: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== '0 || in_flight !== '0) begin
        errors++;
        $display("FAIL rmid_dropped_%0d: got rv=%b if=%0d want 0/0", c, resp_valid, in_flight);
      end
      if (c == 0) begin
        checks++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || resp_data !== 32'd0) begin
          errors++;
          $display("FAIL rmid_outputs: got a=%h b=%h rd=%h want 0", add_a, add_b, resp_data);
        end
      end
    end
    tick();
    for (int i = 0; i < N; i++) set_req(i, rnd_f32(), rnd_f32());
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_restart_grant: got %b want 0001", req_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_overlap();
    logic [31:0] a2;
    logic [31:0] b2;
    tick();
    req_valid = 4'b0001;
    set_req(0, rnd_f32(), rnd_f32());
    @(negedge clk);
    tick();
    req_valid = '0;
    repeat (4) tick();
    a2 = rnd_f32();
    b2 = rnd_f32();
    req_valid = 4'b0010;
    set_req(1, a2, b2);
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || req_ready !== 4'b0010 || in_flight !== CW'(1)) begin
      errors++;
      $display("FAIL overlap_same_cycle: got rv=%b rr=%b if=%0d want 0001/0010/1",
               resp_valid, req_ready, in_flight);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (in_flight !== CW'(1) || req_ready !== '0) begin
      errors++;
      $display("FAIL overlap_after: got if=%0d rr=%b want 1/0000", in_flight, req_ready);
    end
    @(negedge clk);
    checks++;
    if (add_a !== a2 || add_b !== b2) begin
      errors++;
      $display("FAIL idle_hold_operands: got %h/%h want %h/%h", add_a, add_b, a2, b2);
    end
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, rnd_f32(), rnd_f32());
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(i, rnd_f32(), rnd_f32());
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    drain();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_pair();
    test_back_to_back();
    test_reset_mid();
    test_overlap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
